dual_edge_accum: RTL

Downstream consumer of the mixed-edge arithmetic stage. That stage launches signed results on posedge clk. This block captures them on negedge clk, half a cycle later, and accumulates them on the following posedge into per-frame signed sums. Each completed sum is presented, with beat count and overflow flag, on a valid/ready output port.

---
 rtl/dual_edge_pkg.sv | 15 +
 rtl/acc_add_sat.sv | 31 +++
 rtl/dual_edge_accum.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dual_edge_pkg.sv
// Shared state encoding and default widths for the dual-edge frame accumulator.
package dual_edge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_IN_W      = 8;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_MAX_COUNT = 16;
    localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/acc_add_sat.sv
// Signed accumulate step with overflow detect; wraps by default, clamps when
// DUAL_EDGE_ACCUM_SAT_EN is defined.
module acc_add_sat #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [IN_W-1:0]  add_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    ovf_o
);

    logic signed [ACC_W-1:0] add_ext;
    logic signed [ACC_W-1:0] raw;

    always_comb begin
        add_ext = add_i;
        raw     = acc_i + add_ext;
        // Overflow only when both operands share a sign the result does not.
        ovf_o   = (acc_i[ACC_W-1] == add_ext[ACC_W-1]) && (raw[ACC_W-1] != acc_i[ACC_W-1]);
`ifdef DUAL_EDGE_ACCUM_SAT_EN
        if (ovf_o)
            sum_o = acc_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum_o = raw;
`else
        sum_o = raw;
`endif
    end

endmodule

// File: rtl/dual_edge_accum.sv
// Captures posedge-launched samples on negedge and sums them per frame on the
// next posedge. Optional clamping via DUAL_EDGE_ACCUM_SAT_EN (see acc_add_sat).
module dual_edge_accum
    import dual_edge_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int MAX_COUNT = DEF_MAX_COUNT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_ovf,
    input  logic                    out_ready
);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic                    cap_vld_q, cap_vld_d;
    logic signed [IN_W-1:0]  cap_data_q, cap_data_d;
    logic                    cap_last_q, cap_last_d;

    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;
    logic [CNT_W-1:0]        cnt_inc;

    // Negedge capture; in_ready is posedge state so it is settled by now.
    always_comb begin
        cap_vld_d  = in_valid && in_ready;
        cap_data_d = cap_vld_d ? in_data : cap_data_q;
        cap_last_d = cap_vld_d ? in_last : cap_last_q;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_q  <= 1'b0;
            cap_data_q <= '0;
            cap_last_q <= 1'b0;
        end else begin
            cap_vld_q  <= cap_vld_d;
            cap_data_q <= cap_data_d;
            cap_last_q <= cap_last_d;
        end
    end

    acc_add_sat #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i (acc_q),
        .add_i (cap_data_q),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (cap_vld_q) begin
                    acc_d   = cap_data_q;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (cap_last_q || MAX_COUNT == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (cap_vld_q) begin
                    acc_d   = add_sum;
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_q | add_ovf;
                    state_d = (cap_last_q || cnt_inc == CNT_W'(MAX_COUNT)) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_data  = out_valid ? acc_q : '0;
        out_count = out_valid ? cnt_q : '0;
        out_ovf   = out_valid && ovf_q;
    end

endmodule
